// File: rtl/tk1_word_sequencer_if.sv
// Handshake bundle between the TK1 word sequencer and its controller.
// The sequencer uses the slave view; the controller or bench uses master.
interface tk1_word_sequencer_if;
    logic        init;
    logic        inc;
    logic [7:0]  dom;
    logic        start;
    logic [31:0] pdo;
    logic        se;
    logic        busy;
    logic        done;
    logic [55:0] cnt;

    modport master (
        output init, inc, dom, start,
        input  pdo, se, busy, done, cnt
    );

    modport slave (
        input  init, inc, dom, start,
        output pdo, se, busy, done, cnt
    );
endinterface

// File: rtl/tk1_word_sequencer.sv
// Romulus 56-bit LFSR block counter plus domain byte, serialized as four
// 32-bit TK1 words (MSW first) into the 32-bit tweakey shift chain.
module tk1_word_sequencer #(
    parameter logic [55:0] CNT_INIT = 56'h00000000000001
) (
    input  logic                  clk,
    input  logic                  rst,
    tk1_word_sequencer_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state_reg;
    logic [55:0] cnt_reg;
    logic [55:0] cnt_next;
    logic [63:0] snap_reg;
    logic [1:0]  idx_reg;
    logic [31:0] pdo_reg;
    logic        se_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [31:0] w0;
    logic [31:0] w1;

    // Counter bytes are laid out little-end-first into TK1, so each word is
    // a byte-reversed slice of cnt.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_w0
            assign w0[31-8*gi -: 8] = cnt_reg[8*gi+7 -: 8];
        end
        for (gi = 0; gi < 3; gi++) begin : g_w1
            assign w1[31-8*gi -: 8] = cnt_reg[32+8*gi+7 -: 8];
        end
    endgenerate
    assign w1[7:0] = bus.dom;

    // x^56 + x^7 + x^4 + x^2 + 1
    always_comb begin
        cnt_next = cnt_reg;
        if (bus.init) begin
            cnt_next = CNT_INIT;
        end else if (bus.inc) begin
            cnt_next = {cnt_reg[54:0], 1'b0} ^ (cnt_reg[55] ? 56'h95 : 56'h0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= CNT_INIT;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // snap_reg is a word shifter: the word to emit next sits in [63:32].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            snap_reg  <= 64'h0;
            idx_reg   <= 2'd0;
            pdo_reg   <= 32'h0;
            se_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        state_reg <= ST_SHIFT;
                        snap_reg  <= {w1, 32'h0};
                        idx_reg   <= 2'd0;
                        pdo_reg   <= w0;
                        se_reg    <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (idx_reg == 2'd3) begin
                        state_reg <= ST_DONE;
                        pdo_reg   <= 32'h0;
                        se_reg    <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg  <= idx_reg + 2'd1;
                        pdo_reg  <= snap_reg[63:32];
                        snap_reg <= {snap_reg[31:0], 32'h0};
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    pdo_reg   <= 32'h0;
                    se_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pdo  = pdo_reg;
    assign bus.se   = se_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.cnt  = cnt_reg;

endmodule

// File: tb/tb_tk1_word_sequencer.sv
// Directed bench for tk1_word_sequencer: counter stepping, word layout,
// start/inc interaction, ignored starts and asynchronous abort.
module tb_tk1_word_sequencer;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    tk1_word_sequencer_if bus ();

    tk1_word_sequencer #(.CNT_INIT(56'h00000000000001)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
        $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [31:0] pdo_e, input logic se_e,
                             input logic busy_e, input logic done_e);
        check({tag, ".pdo"},  {32'h0, bus.pdo}, {32'h0, pdo_e});
        check({tag, ".se"},   {63'h0, bus.se},  {63'h0, se_e});
        check({tag, ".busy"}, {63'h0, bus.busy}, {63'h0, busy_e});
        check({tag, ".done"}, {63'h0, bus.done}, {63'h0, done_e});
    endtask

    // Called right after the start edge: checks w0..w3, done pulse, idle.
    task automatic run_words(input string tag, input logic [31:0] w0, input logic [31:0] w1);
        check_out({tag, ".w0"}, w0, 1'b1, 1'b1, 1'b0);
        step();
        check_out({tag, ".w1"}, w1, 1'b1, 1'b1, 1'b0);
        step();
        check_out({tag, ".w2"}, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        check_out({tag, ".w3"}, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        check_out({tag, ".done"}, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        check_out({tag, ".idle"}, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_init();
        bus.init = 1'b1;
        step();
        bus.init = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus.init    = 1'b0;
        bus.inc     = 1'b0;
        bus.start   = 1'b0;
        bus.dom     = 8'h00;
        #2;
        check_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        check("reset.cnt", {8'h0, bus.cnt}, 64'h1);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic serialization from reset value
        bus.dom   = 8'h08;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("t1.cnt", {8'h0, bus.cnt}, 64'h1);
        run_words("t1", 32'h01000000, 32'h00000008);

        // 55 steps: single bit reaches the top, no feedback yet
        do_init();
        check("t2.init_cnt", {8'h0, bus.cnt}, 64'h1);
        bus.inc = 1'b1;
        for (int i = 0; i < 55; i++) step();
        bus.inc = 1'b0;
        check("t2.cnt", {8'h0, bus.cnt}, 64'h0080000000000000);
        bus.dom   = 8'h04;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_words("t2", 32'h00000000, 32'h00008004);

        // 56 steps: feedback wraps to 0x95
        do_init();
        bus.inc = 1'b1;
        for (int i = 0; i < 56; i++) step();
        bus.inc = 1'b0;
        check("t3.cnt", {8'h0, bus.cnt}, 64'h95);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_words("t3", 32'h95000000, 32'h00000004);

        // start and inc together: snapshot uses the pre-increment counter
        do_init();
        bus.dom   = 8'h0C;
        bus.start = 1'b1;
        bus.inc   = 1'b1;
        step();
        bus.start = 1'b0;
        bus.inc   = 1'b0;
        check("t4.cnt", {8'h0, bus.cnt}, 64'h2);
        run_words("t4", 32'h01000000, 32'h0000000C);
        bus.init = 1'b1;
        bus.inc  = 1'b1;
        step();
        bus.init = 1'b0;
        bus.inc  = 1'b0;
        check("t4.init_wins", {8'h0, bus.cnt}, 64'h1);

        // start and inc during SHIFT; start during DONE ignored; back-to-back
        bus.dom   = 8'h20;
        bus.start = 1'b1;
        step();
        check_out("t5.w0", 32'h01000000, 1'b1, 1'b1, 1'b0);
        bus.inc = 1'b1;
        step();
        check_out("t5.w1", 32'h00000020, 1'b1, 1'b1, 1'b0);
        check("t5.cnt1", {8'h0, bus.cnt}, 64'h2);
        step();
        check_out("t5.w2", 32'h0, 1'b1, 1'b1, 1'b0);
        check("t5.cnt2", {8'h0, bus.cnt}, 64'h4);
        step();
        check_out("t5.w3", 32'h0, 1'b1, 1'b1, 1'b0);
        check("t5.cnt3", {8'h0, bus.cnt}, 64'h8);
        bus.inc = 1'b0;
        step();
        check_out("t5.done", 32'h0, 1'b0, 1'b0, 1'b1);
        check("t5.cnt4", {8'h0, bus.cnt}, 64'h8);
        step();
        check_out("t5.ignored", 32'h0, 1'b0, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        run_words("t5b", 32'h08000000, 32'h00000020);

        // Asynchronous abort in the second SHIFT cycle
        bus.inc   = 1'b1;
        bus.dom   = 8'h08;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.inc   = 1'b0;
        step();
        check_out("t6.w1", 32'h00000008, 1'b1, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_out("t6.abort", 32'h0, 1'b0, 1'b0, 1'b0);
        check("t6.cnt", {8'h0, bus.cnt}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("t6.held", 32'h0, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        step();
        check_out("t6.nodone", 32'h0, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        run_words("t6", 32'h01000000, 32'h00000008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tk1_word_sequencer.md
Name: tk1_word_sequencer

Overview:
Upstream feeder for the 32-bit tweakey shift chain. It holds the Romulus 56-bit LFSR block counter and a latched domain-separation byte, and builds the 128-bit TK1 value from them. On request it serializes TK1 as four 32-bit words, most-significant word first. Its word output drives the chain's pdi input and its shift strobe drives the chain's se input.

Parameters:
CNT_INIT, 56'h00000000000001, counter value loaded on reset and on init.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset; asynchronous, active-high.
init  input  1  load counter with CNT_INIT.
inc  input  1  advance counter by one LFSR step.
dom  input  8  domain-separation byte; sampled only when start is accepted.
start  input  1  request serialization of current TK1.
pdo  output  32  tweakey word to the chain's pdi.
se  output  1  shift-enable to the tweakey chain; high exactly while pdo is valid.
busy  output  1  high while a serialization is in flight (SHIFT state).
done  output  1  single-cycle pulse after the last word.
cnt  output  56  current counter value, for debug and for compare logic.

Behaviour:
- Reset (async, rst=1): state=IDLE, cnt=CNT_INIT, snapshot buffer=0, word index=0, pdo=0, se=0, busy=0, done=0.
- LFSR step: cnt_next = {cnt[54:0],1'b0} ^ (cnt[55] ? 56'h95 : 56'h0), i.e. polynomial x^56+x^7+x^4+x^2+1. Period is 2^56-1. Zero is unreachable from a nonzero start. A CNT_INIT of 0 is illegal and unsupported.
- Counter priority per cycle: init > inc > hold. The counter updates in any state, including SHIFT.
- TK1 byte layout (byte 0 = tk[127:120]): byte k = cnt[8k+7:8k] for k=0..6; byte 7 = dom; bytes 8..15 = 0.
- Words, in emission order:
  - w0 = {cnt[7:0],cnt[15:8],cnt[23:16],cnt[31:24]}
  - w1 = {cnt[39:32],cnt[47:40],cnt[55:48],dom}
  - w2 = 0
  - w3 = 0
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: on start=1, capture w0 and w1 into a 64-bit snapshot using the pre-update cnt of that cycle and the current dom. Clear the word index and go to SHIFT. If init or inc is also asserted in that cycle, it updates the counter but does not affect the snapshot.
  - SHIFT: se=1 and busy=1 for exactly 4 consecutive cycles. pdo = w0, w1, w2, w3 for index 0..3. The index increments each cycle. After index 3, go to DONE.
  - DONE: done=1, se=0, busy=0, pdo=0 for one cycle, then go to IDLE.
- Latency: start sampled at edge N gives se=1 with w0 on the cycle after edge N (registered outputs). done is high on the 5th cycle after edge N.
- start while in SHIFT or DONE is ignored; it is neither queued nor does it extend the sequence. start in IDLE back-to-back with a DONE cycle is legal. Minimum spacing is 6 cycles start-to-start.
- init or inc during SHIFT changes cnt immediately. In-flight words always come from the snapshot.
- pdo=0 whenever se=0.
- rst asserted mid-SHIFT aborts immediately: se, busy, pdo clear asynchronously and no done pulse is produced.

Test Plan:
- Reset then start with dom=8'h08 → cnt=56'h1; se high 4 cycles; pdo = 32'h01000000, 32'h00000008, 0, 0; done pulses on the following cycle; busy low afterwards.
- init, then 55 inc pulses, then start with dom=8'h04 → cnt=56'h80000000000000; pdo = 32'h00000000, 32'h00008004, 0, 0.
- init, then 56 inc pulses, then start with dom=8'h04 → cnt=56'h95 (feedback wrap); pdo = 32'h95000000, 32'h00000004, 0, 0.
- start and inc in the same cycle from cnt=1, dom=8'h0C → words use cnt=1 (32'h01000000, 32'h0000000C); cnt=2 afterwards. Also assert init and inc together: cnt=CNT_INIT (init wins).
- start re-asserted during SHIFT, and inc asserted during SHIFT → sequence is still exactly 4 words; in-flight words unchanged; counter advanced.
- Assert rst during the second SHIFT cycle → se, busy and pdo go to 0 without waiting for a clock edge; no done pulse; cnt=CNT_INIT; a fresh start works normally.
